mlp_compute_sequencer: RTL and testbench
========================================

MLP_COMPUTE_SEQUENCER -- requirements
Module: mlp_compute_sequencer

Interface
REQ-001 SHALL have parameter BRAM_A_RDADDR_WIDTH, default 9, the width of the 'A' BRAM read address.
REQ-002 SHALL have parameter BRAM_B_RDADDR_WIDTH, default 9, the width of the 'B' BRAM read address.
REQ-003 SHALL have parameter LEN_WIDTH, default 9, the width of the step count per block.
REQ-004 SHALL have parameter BLK_WIDTH, default 8, the width of the block count.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-006 i_clk  input  1  sole clock; all logic on rising edge.
REQ-007 i_reset_n  input  1  asynchronous active-low reset.
REQ-008 i_start  input  1  single-cycle job request.
REQ-009 i_abort  input  1  synchronous job cancel.
REQ-010 i_base_a  input  BRAM_A_RDADDR_WIDTH  'A' start address, sampled at start.
REQ-011 i_base_b  input  BRAM_B_RDADDR_WIDTH  'B' start address, sampled at start.
REQ-012 i_length  input  LEN_WIDTH  steps per block (N), sampled at start.
REQ-013 i_num_blocks  input  BLK_WIDTH  blocks per job (M), sampled at start.
REQ-014 i_result_almost_full  input  1  result FIFO backpressure.
REQ-015 o_bram_a_rdaddr  output  BRAM_A_RDADDR_WIDTH  'A' read address.
REQ-016 o_bram_b_rdaddr  output  BRAM_B_RDADDR_WIDTH  'B' read address.
REQ-017 o_first / o_pause / o_last  output  1 each  MLP accumulate controls.
REQ-018 o_busy  output  1  job in progress.
REQ-019 o_done  output  1  single-cycle job-complete pulse.
REQ-020 o_block_count  output  BLK_WIDTH  blocks fully issued in the current or last job.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-023 i_start SHALL be accepted only in IDLE; it is ignored in all other states.
REQ-024 On accept with N>=1 and M>=1: inputs latched, o_block_count cleared, next state RUN.
REQ-025 On accept with N=0 or M=0: next state DONE, no step issued, o_block_count=0.
REQ-026 A step for block j (0..M-1), index k (0..N-1) SHALL present o_bram_a_rdaddr=base_a+k and o_bram_b_rdaddr=base_b+j*N+k, both truncated modulo 2^width (wrap permitted).
REQ-027 A step cycle SHALL drive o_pause=0, o_first=(k==0) and o_last=(k==N-1); for N=1, o_first and o_last are both high in the same cycle.
REQ-028 The first step SHALL appear on the outputs 1 cycle after start is accepted.
REQ-029 Consecutive steps, including the step from block j's last to block j+1's first, SHALL be back-to-back absent backpressure.
REQ-030 In RUN or HOLD, i_result_almost_full=1 SHALL make the next output cycle a HOLD cycle: o_pause=1, o_first=0, o_last=0, addresses held, step index not advanced.
REQ-031 When i_result_almost_full returns to 0, the next cycle SHALL issue the held (next un-issued) step.
REQ-032 o_block_count SHALL increment in the cycle after each o_last step.
REQ-033 The cycle after the final o_last step, the FSM SHALL be in DONE: o_done=1 for exactly 1 cycle and o_busy=0; it then returns to IDLE.
REQ-034 o_busy SHALL be 1 from the cycle after accept until the DONE cycle (exclusive).
REQ-035 In IDLE and DONE, o_pause=1, o_first=0, o_last=0, and addresses hold their last value.
REQ-036 i_abort in RUN or HOLD SHALL force IDLE next cycle with o_pause=1, and SHALL issue no further o_last and no o_done; o_block_count holds.
REQ-037 i_abort and i_start in the same IDLE cycle: abort wins, start ignored.

Reset
REQ-038 On i_reset_n=0, the sequencer SHALL immediately enter IDLE with o_pause=1 and every other output (addresses, o_first, o_last, o_busy, o_done, o_block_count) at 0.
REQ-039 Reset mid-job SHALL discard the job, with no o_done; deassertion SHALL be synchronised before the FSM is used.

Structure
REQ-040 The FSM state enum and the default address/length widths SHALL live in shared package mlp_seq_pkg.
REQ-041 No sub-module is required; the output stage SHALL reuse the existing pipeline module only if extra output registers are added for timing.

Verification
REQ-042 The bench SHALL cover: N=4, M=2, base_a=0, base_b=0x10, no backpressure -> 8 contiguous steps; A addr 0,1,2,3,0,1,2,3; B addr 0x10..0x17; o_first at steps 0 and 4; o_last at steps 3 and 7; o_done 1 cycle after step 7; o_block_count=2.
REQ-043 The bench SHALL cover: N=1, M=3 -> 3 cycles each with o_first=o_last=1; B addr base_b, base_b+1, base_b+2.
REQ-044 The bench SHALL cover: N=8, almost_full high for 3 cycles after the 2nd step -> 3 pause cycles with address held at step 2, then steps 2..7 resume; o_done after 11 output cycles.
REQ-045 The bench SHALL cover: base_b=0x1FE, N=4, M=1 -> B addr 0x1FE, 0x1FF, 0x000, 0x001.
REQ-046 The bench SHALL cover: abort at step 5 of N=8 -> o_pause=1 next cycle, no o_last, no o_done, o_busy=0; a following start runs normally.
REQ-047 The bench SHALL cover: N=0 -> o_done 1 cycle after start, no step issued; i_start during busy -> ignored.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared types and default widths for the MLP compute sequencer.
package mlp_seq_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 9;
  localparam int unsigned DEF_LEN_WIDTH  = 9;
  localparam int unsigned DEF_BLK_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mlp_compute_sequencer_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases two clock edges after i_reset_n rises.
module mlp_compute_sequencer_rst_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_reset_n
);

  logic [1:0] sync_q;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], 1'b1};
  end

  assign o_reset_n = sync_q[1];

endmodule

// File: rtl/mlp_compute_sequencer.sv
// Issues A/B BRAM read addresses and first/pause/last accumulate controls for an
// M-block by N-step MLP job, with result-FIFO backpressure and abort.
module mlp_compute_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int BRAM_A_RDADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BRAM_B_RDADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH           = DEF_LEN_WIDTH,
  parameter int BLK_WIDTH           = DEF_BLK_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [BRAM_A_RDADDR_WIDTH-1:0] i_base_a,
  input  logic [BRAM_B_RDADDR_WIDTH-1:0] i_base_b,
  input  logic [LEN_WIDTH-1:0]           i_length,
  input  logic [BLK_WIDTH-1:0]           i_num_blocks,
  input  logic                           i_result_almost_full,
  output logic [BRAM_A_RDADDR_WIDTH-1:0] o_bram_a_rdaddr,
  output logic [BRAM_B_RDADDR_WIDTH-1:0] o_bram_b_rdaddr,
  output logic                           o_first,
  output logic                           o_pause,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [BLK_WIDTH-1:0]           o_block_count
);

  logic rst_n;

  mlp_compute_sequencer_rst_sync u_rst_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_reset_n (rst_n)
  );

  seq_state_t                     state;
  logic [BRAM_A_RDADDR_WIDTH-1:0] base_a_q;
  logic [BRAM_B_RDADDR_WIDTH-1:0] b_next_q;
  logic [LEN_WIDTH-1:0]           len_q;
  logic [LEN_WIDTH-1:0]           k_q;
  logic [BLK_WIDTH-1:0]           blk_q;
  logic [BLK_WIDTH-1:0]           j_q;
  logic                           issued_all_q;

  // Step about to be issued: taken straight from the inputs on accept, else from the job registers.
  logic [LEN_WIDTH-1:0]           k_c, n_c;
  logic [BLK_WIDTH-1:0]           j_c, m_c;
  logic [BRAM_A_RDADDR_WIDTH-1:0] ba_c;
  logic [BRAM_B_RDADDR_WIDTH-1:0] bb_c;
  logic                           step_last, step_final;
  logic                           accept, empty_job, do_issue;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    k_c  = k_q;
    j_c  = j_q;
    n_c  = len_q;
    m_c  = blk_q;
    ba_c = base_a_q;
    bb_c = b_next_q;
    if (state == ST_IDLE) begin
      k_c  = '0;
      j_c  = '0;
      n_c  = i_length;
      m_c  = i_num_blocks;
      ba_c = i_base_a;
      bb_c = i_base_b;
    end
  end

  // k+1 and j+1 never exceed N and M, so the additions cannot wrap.
  assign step_last  = (k_c + LEN_WIDTH'(1)) == n_c;
  assign step_final = step_last && ((j_c + BLK_WIDTH'(1)) == m_c);
  assign accept     = (state == ST_IDLE) && i_start && !i_abort;
  assign empty_job  = (i_length == '0) || (i_num_blocks == '0);
  assign do_issue   = (accept && !empty_job) ||
                      (((state == ST_RUN) || (state == ST_HOLD)) &&
                       !i_abort && !issued_all_q && !i_result_almost_full);

  // NOTE: job registers are reset along with the outputs so no X can leak into addresses after reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      base_a_q        <= '0;
      b_next_q        <= '0;
      len_q           <= '0;
      k_q             <= '0;
      blk_q           <= '0;
      j_q             <= '0;
      issued_all_q    <= 1'b0;
      o_bram_a_rdaddr <= '0;
      o_bram_b_rdaddr <= '0;
      o_first         <= 1'b0;
      o_pause         <= 1'b1;
      o_last          <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_block_count   <= '0;
    end else begin
      o_done  <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_pause <= 1'b1;

      // A block counts once its last step has been on the outputs; an abort freezes the count.
      if (o_last && !i_abort) o_block_count <= o_block_count + BLK_WIDTH'(1);

      if (do_issue) begin
        o_bram_a_rdaddr <= ba_c + BRAM_A_RDADDR_WIDTH'(k_c);
        o_bram_b_rdaddr <= bb_c;
        o_first         <= (k_c == '0);
        o_last          <= step_last;
        o_pause         <= 1'b0;
        b_next_q        <= bb_c + BRAM_B_RDADDR_WIDTH'(1);
        k_q             <= step_last ? '0 : k_c + LEN_WIDTH'(1);
        j_q             <= step_last ? j_c + BLK_WIDTH'(1) : j_c;
        issued_all_q    <= step_final;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            base_a_q      <= i_base_a;
            len_q         <= i_length;
            blk_q         <= i_num_blocks;
            o_block_count <= '0;
            if (empty_job) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= ST_RUN;
              o_busy <= 1'b1;
            end
          end
        end
        ST_RUN, ST_HOLD: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (issued_all_q) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else if (i_result_almost_full) begin
            state <= ST_HOLD;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_compute_sequencer.sv
// Directed and randomized jobs checked against a step-list model of the sequencer.
module tb_mlp_compute_sequencer;

  localparam int AW = 9;
  localparam int BW = 9;
  localparam int LW = 9;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_abort, i_af;
  logic [AW-1:0] i_base_a;
  logic [BW-1:0] i_base_b;
  logic [LW-1:0] i_length;
  logic [KW-1:0] i_num_blocks;
  logic [AW-1:0] o_a;
  logic [BW-1:0] o_b;
  logic          o_first, o_pause, o_last, o_busy, o_done;
  logic [KW-1:0] o_blk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int last_a = 0;
  int last_b = 0;

  always #5 clk = ~clk;

  mlp_compute_sequencer #(
    .BRAM_A_RDADDR_WIDTH (AW),
    .BRAM_B_RDADDR_WIDTH (BW),
    .LEN_WIDTH           (LW),
    .BLK_WIDTH           (KW)
  ) dut (
    .i_clk                (clk),
    .i_reset_n            (rst_n),
    .i_start              (i_start),
    .i_abort              (i_abort),
    .i_base_a             (i_base_a),
    .i_base_b             (i_base_b),
    .i_length             (i_length),
    .i_num_blocks         (i_num_blocks),
    .i_result_almost_full (i_af),
    .o_bram_a_rdaddr      (o_a),
    .o_bram_b_rdaddr      (o_b),
    .o_first              (o_first),
    .o_pause              (o_pause),
    .o_last               (o_last),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_block_count        (o_blk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int a, input int b, input bit first,
                            input bit last, input bit pause, input bit busy, input bit done,
                            input int blk);
    check({tag, ".a"},     o_a,     a);
    check({tag, ".b"},     o_b,     b);
    check({tag, ".first"}, o_first, first);
    check({tag, ".last"},  o_last,  last);
    check({tag, ".pause"}, o_pause, pause);
    check({tag, ".busy"},  o_busy,  busy);
    check({tag, ".done"},  o_done,  done);
    check({tag, ".blk"},   o_blk,   blk);
  endtask

  // One job: expected trace is the flat list of (j,k) steps, one per cycle, with a pause
  // after every cycle in which almost_full was high, then a single done cycle.
  task automatic run_job(input string tag, input int ba, input int bb, input int n, input int m,
                         input int abort_at, input int start_at, input bit rand_af,
                         input int af_from, input int af_len);
    int  total, issued, exp_blk, j, k;
    bit  prev_af, prev_abort, fin, af_c;
    total      = n * m;
    issued     = 0;
    prev_af    = 1'b0;
    prev_abort = 1'b0;
    fin        = 1'b0;
    @(negedge clk);
    i_start      = 1'b1;
    i_abort      = 1'b0;
    i_base_a     = ba[AW-1:0];
    i_base_b     = bb[BW-1:0];
    i_length     = n[LW-1:0];
    i_num_blocks = m[KW-1:0];
    @(negedge clk);
    i_start      = 1'b0;
    i_base_a     = AW'($urandom);
    i_base_b     = BW'($urandom);
    i_length     = LW'($urandom);
    i_num_blocks = KW'($urandom);
    for (int c = 0; c < 300 && !fin; c++) begin
      exp_blk = (n == 0) ? 0 : issued / n;
      if (prev_abort) begin
        check_outs({tag, ".abort"}, last_a, last_b, 0, 0, 1, 0, 0, exp_blk);
        fin = 1'b1;
      end else if (issued == total) begin
        check_outs({tag, ".done"}, last_a, last_b, 0, 0, 1, 0, 1, exp_blk);
        fin = 1'b1;
      end else if (prev_af) begin
        check_outs({tag, ".hold"}, last_a, last_b, 0, 0, 1, 1, 0, exp_blk);
      end else begin
        j      = issued / n;
        k      = issued % n;
        last_a = (ba + k) & ((1 << AW) - 1);
        last_b = (bb + j * n + k) & ((1 << BW) - 1);
        check_outs({tag, ".step"}, last_a, last_b, k == 0, k == n - 1, 0, 1, 0, exp_blk);
        issued++;
      end
      af_c       = rand_af ? ($urandom_range(0, 3) == 0) : (c >= af_from && c < af_from + af_len);
      prev_af    = af_c;
      i_af       = af_c;
      prev_abort = (c == abort_at);
      i_abort    = (c == abort_at);
      i_start    = (c == start_at);
      @(negedge clk);
    end
    check({tag, ".timeout"}, fin, 1);
    i_af    = 1'b0;
    i_abort = 1'b0;
    i_start = 1'b0;
    exp_blk = (n == 0) ? 0 : issued / n;
    for (int c = 0; c < 2; c++) begin
      check_outs({tag, ".idle"}, last_a, last_b, 0, 0, 1, 0, 0, exp_blk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_af         = 1'b0;
    i_base_a     = '0;
    i_base_b     = '0;
    i_length     = '0;
    i_num_blocks = '0;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_outs("post_reset", 0, 0, 0, 0, 1, 0, 0, 0);

    run_job("basic",     'h000, 'h010, 4, 2, -1, -1, 1'b0, 0, 0);
    run_job("n1",        'h005, 'h040, 1, 3, -1, -1, 1'b0, 0, 0);
    run_job("backpress", 'h020, 'h080, 8, 1, -1,  6, 1'b0, 1, 3);
    run_job("wrap",      'h1FD, 'h1FE, 4, 1, -1, -1, 1'b0, 0, 0);
    run_job("abort",     'h030, 'h100, 8, 1,  5, -1, 1'b0, 0, 0);
    run_job("after_ab",  'h011, 'h022, 2, 2, -1, -1, 1'b0, 0, 0);
    run_job("n0",        'h044, 'h055, 0, 3, -1, -1, 1'b0, 0, 0);
    run_job("m0",        'h044, 'h055, 5, 0, -1, -1, 1'b0, 0, 0);

    // Abort and start together in IDLE: start must be ignored.
    i_start      = 1'b1;
    i_abort      = 1'b1;
    i_length     = 9'd3;
    i_num_blocks = 8'd1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    check_outs("ab_start", last_a, last_b, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check_outs("ab_start2", last_a, last_b, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of a job: outputs clear at once, job is discarded.
    i_start      = 1'b1;
    i_base_a     = 9'h010;
    i_base_b     = 9'h020;
    i_length     = 9'd8;
    i_num_blocks = 8'd2;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs("mid_reset", 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_a = 0;
    last_b = 0;
    for (int c = 0; c < 4; c++) begin
      check_outs("reset_rel", 0, 0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
    end
    run_job("post_rst", 'h003, 'h0F0, 3, 2, -1, -1, 1'b0, 0, 0);

    for (int r = 0; r < 5; r++) begin
      run_job("rand", $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(1, 6),
              $urandom_range(1, 3), -1, 2, 1'b1, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
